// File: rtl/cpu_seq_pkg.sv
// Shared definitions for cpu_seq: opcode encoding, architectural register
// names and instruction field positions.
// The LDI/WRO/ADD/SUB values are kept from the original single-cycle core,
// so existing ROM images still decode the same way.
package cpu_seq_pkg;

  typedef enum logic [3:0] {
    INST_NOP = 4'h0,
    INST_LDI = 4'h1,
    INST_WRO = 4'h2,
    INST_ADD = 4'h3,
    INST_SUB = 4'h4,
    INST_AND = 4'h5,
    INST_OR  = 4'h6,
    INST_XOR = 4'h7,
    INST_SHL = 4'h8,
    INST_MOV = 4'h9,
    INST_JMP = 4'hA,
    INST_JZ  = 4'hB,
    INST_JC  = 4'hC,
    INST_HLT = 4'hF
  } op_e;

  localparam logic [3:0] AX = 4'd0;
  localparam logic [3:0] BX = 4'd1;
  localparam logic [3:0] CX = 4'd2;
  localparam logic [3:0] DX = 4'd3;

  // Instruction fields: op=[15:12] ra=[11:8] imm=[7:0], with imm = {rb, rc}
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RA_HI  = 11;
  localparam int RA_LO  = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
  localparam int RB_HI  = 7;
  localparam int RB_LO  = 4;
  localparam int RC_HI  = 3;
  localparam int RC_LO  = 0;

endpackage

// File: rtl/cpu_seq_alu.sv
// Combinational ALU for cpu_seq.
// Ports:
//   op_i      opcode of the instruction being executed
//   a_i, b_i  source operands r[ra], r[rb]
//   carry_i   current carry flag
//   result_o  value to write to r[rc]
//   carry_o   next carry flag (carry_i for ops that leave it alone)
//   we_o      op writes r[rc]
module cpu_seq_alu
  import cpu_seq_pkg::*;
#(
  parameter int N = 16
) (
  input  op_e          op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         carry_i,
  output logic [N-1:0] result_o,
  output logic         carry_o,
  output logic         we_o
);

  always_comb begin
    result_o = '0;
    carry_o  = carry_i;
    we_o     = 1'b0;
    case (op_i)
      INST_ADD: begin
        {carry_o, result_o} = {1'b0, a_i} + {1'b0, b_i};
        we_o = 1'b1;
      end
      INST_SUB: begin
        result_o = a_i - b_i;
        carry_o  = (a_i < b_i);   // unsigned borrow
        we_o     = 1'b1;
      end
      INST_AND: begin result_o = a_i & b_i; we_o = 1'b1; end
      INST_OR:  begin result_o = a_i | b_i; we_o = 1'b1; end
      INST_XOR: begin result_o = a_i ^ b_i; we_o = 1'b1; end
      INST_SHL: begin
        result_o = {a_i[N-2:0], 1'b0};
        carry_o  = a_i[N-1];
        we_o     = 1'b1;
      end
      INST_MOV: begin result_o = a_i; we_o = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_seq.sv
// cpu_seq: small sequential CPU fetching from a combinational instruction
// ROM, one instruction per cycle when inst_valid is high.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   imem_addr    fetch address (current PC)
//   inst         instruction at imem_addr, valid the same cycle
//   inst_valid   low stalls the core (all state holds)
//   wr_addr/out  address/data latched by WRO
//   out_valid    one-cycle pulse after a WRO executes
//   carry        carry/borrow flag
//   halted       set by HLT, cleared only by reset
module cpu_seq
  import cpu_seq_pkg::*;
#(
  parameter int N    = 16,
  parameter int REGN = 4,
  parameter int PCW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  output logic [PCW-1:0] imem_addr,
  input  logic [15:0]    inst,
  input  logic           inst_valid,
  output logic [15:0]    wr_addr,
  output logic [N-1:0]   out,
  output logic           out_valid,
  output logic           carry,
  output logic           halted
);

  logic [PCW-1:0]           pc_q, pc_d;
  logic [REGN-1:0][N-1:0]   regs_q, regs_d;
  logic [15:0]              wr_addr_q, wr_addr_d;
  logic [N-1:0]             out_q, out_d;
  logic                     out_valid_q, out_valid_d;
  logic                     carry_q, carry_d;
  logic                     halted_q, halted_d;

  op_e        op;
  logic [3:0] ra, rb, rc;
  logic [7:0] imm;

  assign op  = op_e'(inst[OP_HI:OP_LO]);
  assign ra  = inst[RA_HI:RA_LO];
  assign rb  = inst[RB_HI:RB_LO];
  assign rc  = inst[RC_HI:RC_LO];
  assign imm = inst[IMM_HI:IMM_LO];

  // Register file padded to all 16 encodable indices; indices at or above
  // REGN read as zero so any 4-bit field can index it directly.
  logic [15:0][N-1:0] rf_ext;
  for (genvar g = 0; g < 16; g++) begin : g_rd
    if (g < REGN) begin : g_live
      assign rf_ext[g] = regs_q[g];
    end else begin : g_zero
      assign rf_ext[g] = '0;
    end
  end

  logic [N-1:0] opa, opb;
  assign opa = rf_ext[ra];
  assign opb = rf_ext[rb];

  logic [N-1:0] alu_res;
  logic         alu_carry, alu_we;

  cpu_seq_alu #(.N(N)) u_alu (
    .op_i     (op),
    .a_i      (opa),
    .b_i      (opb),
    .carry_i  (carry_q),
    .result_o (alu_res),
    .carry_o  (alu_carry),
    .we_o     (alu_we)
  );

  logic         wen;
  logic [3:0]   waddr;
  logic [N-1:0] wdata;

  always_comb begin
    pc_d        = pc_q;
    regs_d      = regs_q;
    wr_addr_d   = wr_addr_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    carry_d     = carry_q;
    halted_d    = halted_q;
    wen         = 1'b0;
    waddr       = rc;
    wdata       = alu_res;
    if (inst_valid && !halted_q) begin
      pc_d    = pc_q + PCW'(1);
      carry_d = alu_carry;
      wen     = alu_we;
      case (op)
        INST_LDI: begin
          wen   = 1'b1;
          waddr = ra;
          wdata = N'(imm);
        end
        INST_WRO: begin
          out_d       = opa;
          wr_addr_d   = 16'(imm);
          out_valid_d = 1'b1;
        end
        INST_JMP: pc_d = imm[PCW-1:0];
        INST_JZ:  if (opa == '0) pc_d = imm[PCW-1:0];
        INST_JC:  if (carry_q)   pc_d = imm[PCW-1:0];
        INST_HLT: begin
          pc_d     = pc_q;
          halted_d = 1'b1;
        end
        default: ;
      endcase
      // Writes to indices >= REGN match no entry and are dropped
      for (int i = 0; i < REGN; i++) begin
        if (wen && waddr == 4'(i)) regs_d[i] = wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= '0;
      regs_q      <= '0;
      wr_addr_q   <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      regs_q      <= regs_d;
      wr_addr_q   <= wr_addr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      carry_q     <= carry_d;
      halted_q    <= halted_d;
    end
  end

  assign imem_addr = pc_q;
  assign wr_addr   = wr_addr_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign carry     = carry_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_seq.sv
// Self-checking bench for cpu_seq (N=8, REGN=4, PCW=8): directed program
// scenarios checked against hand-derived constants, plus random programs
// checked against an instruction-level reference model.
module tb_cpu_seq;
  import cpu_seq_pkg::*;

  localparam int N    = 8;
  localparam int REGN = 4;
  localparam int PCW  = 8;
  localparam int MASK = (1 << N) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           inst_valid = 1'b0;
  logic [15:0]    inst;
  logic [PCW-1:0] imem_addr;
  logic [15:0]    wr_addr;
  logic [N-1:0]   out;
  logic           out_valid, carry, halted;

  logic [15:0] prog [0:255];
  assign inst = prog[imem_addr];

  always #5 clk = ~clk;

  cpu_seq #(.N(N), .REGN(REGN), .PCW(PCW)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .inst(inst),
    .inst_valid(inst_valid), .wr_addr(wr_addr), .out(out),
    .out_valid(out_valid), .carry(carry), .halted(halted)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: architectural state as plain integers
  int m_pc, m_carry, m_halt, m_out, m_wa, m_ov;
  int m_r [16];

  function automatic logic [15:0] e_i(int op, int ra, int imm);
    return 16'((op << 12) | ((ra & 15) << 8) | (imm & 255));
  endfunction

  function automatic logic [15:0] e_r(int op, int ra, int rb, int rc);
    return e_i(op, ra, ((rb & 15) << 4) | (rc & 15));
  endfunction

  task automatic model_step(input bit r, input bit v);
    int w, op, ra, rb, rc, imm, a, b, res, dst, npc;
    bit wr;
    m_ov = 0;
    if (r) begin
      m_pc = 0; m_carry = 0; m_halt = 0; m_out = 0; m_wa = 0;
      for (int i = 0; i < 16; i++) m_r[i] = 0;
      return;
    end
    if (!v || m_halt != 0) return;
    w   = int'(prog[m_pc]);
    op  = (w >> 12) & 15;
    ra  = (w >> 8) & 15;
    imm = w & 255;
    rb  = (w >> 4) & 15;
    rc  = w & 15;
    a   = (ra < REGN) ? m_r[ra] : 0;
    b   = (rb < REGN) ? m_r[rb] : 0;
    npc = (m_pc + 1) % (1 << PCW);
    wr  = 0; dst = rc; res = 0;
    case (op)
      1:  begin wr = 1; dst = ra; res = imm; end
      2:  begin m_out = a; m_wa = imm; m_ov = 1; end
      3:  begin res = a + b; m_carry = (res > MASK) ? 1 : 0; res = res & MASK; wr = 1; end
      4:  begin m_carry = (a < b) ? 1 : 0; res = (a - b) & MASK; wr = 1; end
      5:  begin res = a & b; wr = 1; end
      6:  begin res = a | b; wr = 1; end
      7:  begin res = a ^ b; wr = 1; end
      8:  begin m_carry = (a > MASK / 2) ? 1 : 0; res = (a * 2) & MASK; wr = 1; end
      9:  begin res = a; wr = 1; end
      10: npc = imm % (1 << PCW);
      11: if (a == 0) npc = imm % (1 << PCW);
      12: if (m_carry != 0) npc = imm % (1 << PCW);
      15: begin m_halt = 1; npc = m_pc; end
      default: ;
    endcase
    if (wr && dst < REGN) m_r[dst] = res;
    m_pc = npc;
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge
  task automatic tick(input bit v, input bit r = 1'b0);
    rst = r;
    inst_valid = v;
    model_step(r, v);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
  endtask

  task automatic test_reset();
    clear_prog();
    prog[0] = e_i(INST_LDI, AX, 8'h77);   // must be overridden by reset
    tick(1'b1, 1'b1);
    n_cmp++; if (imem_addr !== 8'd0) begin n_err++; $display("FAIL reset_pc got=%0h exp=0", imem_addr); end
    n_cmp++; if (out !== 8'd0 || wr_addr !== 16'd0) begin n_err++; $display("FAIL reset_out got=%0h/%0h exp=0/0", out, wr_addr); end
    n_cmp++; if ({out_valid, carry, halted} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=000", {out_valid, carry, halted}); end
  endtask

  task automatic test_wro();
    clear_prog();
    prog[0] = e_i(INST_LDI, AX, 42);
    prog[1] = e_i(INST_WRO, AX, 7);
    tick(1'b1, 1'b1);
    tick(1'b1);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL wro_early_valid got=%b exp=0", out_valid); end
    tick(1'b1);
    n_cmp++; if (out !== 8'd42 || wr_addr !== 16'd7) begin n_err++; $display("FAIL wro_data got=%0d/%0d exp=42/7", out, wr_addr); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL wro_valid got=%b exp=1", out_valid); end
    n_cmp++; if (imem_addr !== 8'd2) begin n_err++; $display("FAIL wro_pc got=%0d exp=2", imem_addr); end
    tick(1'b1);
    n_cmp++; if (out_valid !== 1'b0 || out !== 8'd42) begin n_err++; $display("FAIL wro_pulse got=%b/%0d exp=0/42", out_valid, out); end
  endtask

  task automatic test_arith();
    clear_prog();
    prog[0]  = e_i(INST_LDI, AX, 3);
    prog[1]  = e_i(INST_LDI, BX, 2);
    prog[2]  = e_r(INST_ADD, AX, BX, CX);
    prog[3]  = e_r(INST_ADD, CX, BX, CX);
    prog[4]  = e_r(INST_ADD, CX, BX, CX);
    prog[5]  = e_i(INST_WRO, CX, 0);
    prog[6]  = e_i(INST_LDI, AX, 19);
    prog[7]  = e_i(INST_LDI, BX, 3);
    prog[8]  = e_r(INST_SUB, AX, BX, CX);
    prog[9]  = e_i(INST_WRO, CX, 1);
    prog[10] = e_i(INST_HLT, 0, 0);
    tick(1'b1, 1'b1);
    repeat (6) tick(1'b1);
    n_cmp++; if (out !== 8'd9) begin n_err++; $display("FAIL accum got=%0d exp=9", out); end
    repeat (5) tick(1'b1);
    n_cmp++; if (out !== 8'd16 || carry !== 1'b0) begin n_err++; $display("FAIL sub got=%0d c=%b exp=16 c=0", out, carry); end
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL arith_halt got=%b exp=1", halted); end
  endtask

  task automatic test_carry();
    clear_prog();
    prog[0] = e_i(INST_LDI, AX, 200);
    prog[1] = e_i(INST_LDI, BX, 100);
    prog[2] = e_r(INST_ADD, AX, BX, CX);
    prog[3] = e_i(INST_WRO, CX, 0);
    prog[4] = e_r(INST_SUB, BX, AX, DX);
    prog[5] = e_i(INST_WRO, DX, 1);
    prog[6] = e_i(INST_HLT, 0, 0);
    tick(1'b1, 1'b1);
    repeat (4) tick(1'b1);
    n_cmp++; if (out !== 8'd44 || carry !== 1'b1) begin n_err++; $display("FAIL add_ovf got=%0d c=%b exp=44 c=1", out, carry); end
    repeat (2) tick(1'b1);
    n_cmp++; if (out !== 8'd156 || carry !== 1'b1) begin n_err++; $display("FAIL sub_borrow got=%0d c=%b exp=156 c=1", out, carry); end
  endtask

  task automatic test_loop();
    clear_prog();
    prog[0] = e_i(INST_LDI, AX, 3);
    prog[1] = e_i(INST_LDI, BX, 1);
    prog[2] = e_r(INST_SUB, AX, BX, AX);
    prog[3] = e_i(INST_JZ, AX, 6);
    prog[4] = e_i(INST_JMP, 0, 2);
    prog[6] = e_i(INST_WRO, AX, 0);
    prog[7] = e_i(INST_HLT, 0, 0);
    prog[8] = e_i(INST_LDI, AX, 99);
    tick(1'b1, 1'b1);
    repeat (11) tick(1'b1);
    n_cmp++; if (out_valid !== 1'b1 || out !== 8'd0) begin n_err++; $display("FAIL loop_wro got=%b/%0d exp=1/0", out_valid, out); end
    tick(1'b1);
    n_cmp++; if (halted !== 1'b1 || imem_addr !== 8'd7) begin n_err++; $display("FAIL loop_halt got=%b@%0d exp=1@7", halted, imem_addr); end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      n_cmp++; if (imem_addr !== 8'd7 || out_valid !== 1'b0 || out !== 8'd0) begin n_err++; $display("FAIL halt_hold%0d got=%0d/%b/%0d exp=7/0/0", i, imem_addr, out_valid, out); end
    end
  endtask

  task automatic test_stall();
    clear_prog();
    prog[0] = e_i(INST_LDI, AX, 8'h5A);
    prog[1] = e_i(INST_WRO, AX, 3);
    prog[2] = e_i(INST_HLT, 0, 0);
    tick(1'b1, 1'b1);
    tick(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      n_cmp++; if (imem_addr !== 8'd1 || out_valid !== 1'b0 || out !== 8'd0) begin n_err++; $display("FAIL stall%0d got=%0d/%b/%0d exp=1/0/0", i, imem_addr, out_valid, out); end
    end
    tick(1'b1);
    n_cmp++; if (out !== 8'h5A || wr_addr !== 16'd3 || out_valid !== 1'b1) begin n_err++; $display("FAIL stall_wro got=%0h/%0d/%b exp=5a/3/1", out, wr_addr, out_valid); end
    tick(1'b1);
  endtask

  task automatic test_reset_cases();
    // still halted from the previous scenario
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL pre_rst_halt got=%b exp=1", halted); end
    tick(1'b1, 1'b1);
    n_cmp++; if (imem_addr !== 8'd0 || halted !== 1'b0 || out !== 8'd0 || carry !== 1'b0) begin n_err++; $display("FAIL rst_halted got=%0d/%b/%0d/%b exp=0/0/0/0", imem_addr, halted, out, carry); end
    clear_prog();
    prog[0] = e_i(INST_LDI, AX, 200);
    prog[1] = e_r(INST_ADD, AX, AX, BX);
    prog[2] = e_i(INST_WRO, AX, 5);
    prog[3] = e_i(INST_JMP, 0, 3);
    repeat (5) tick(1'b1);
    n_cmp++; if (carry !== 1'b1 || out !== 8'd200 || imem_addr !== 8'd3) begin n_err++; $display("FAIL midloop got=%b/%0d/%0d exp=1/200/3", carry, out, imem_addr); end
    tick(1'b1, 1'b1);
    n_cmp++; if (imem_addr !== 8'd0 || halted !== 1'b0 || out !== 8'd0 || carry !== 1'b0) begin n_err++; $display("FAIL rst_loop got=%0d/%b/%0d/%b exp=0/0/0/0", imem_addr, halted, out, carry); end
    clear_prog();
    prog[0] = e_i(INST_LDI, AX, 17);
    prog[1] = e_i(INST_LDI, BX, 34);
    prog[2] = e_i(INST_LDI, 15, 8'h55);
    prog[3] = e_i(INST_WRO, AX, 0);
    prog[4] = e_i(INST_WRO, BX, 1);
    prog[5] = e_i(INST_WRO, 15, 2);
    prog[6] = e_i(INST_WRO, CX, 3);
    prog[7] = e_i(INST_HLT, 0, 0);
    repeat (4) tick(1'b1);
    n_cmp++; if (out !== 8'd17) begin n_err++; $display("FAIL r15_ax got=%0d exp=17", out); end
    tick(1'b1);
    n_cmp++; if (out !== 8'd34) begin n_err++; $display("FAIL r15_bx got=%0d exp=34", out); end
    tick(1'b1);
    n_cmp++; if (out !== 8'd0 || wr_addr !== 16'd2 || ^{out, wr_addr, carry} === 1'bx) begin n_err++; $display("FAIL r15_read got=%0h/%0d exp=0/2", out, wr_addr); end
    tick(1'b1);
    n_cmp++; if (out !== 8'd0 || wr_addr !== 16'd3) begin n_err++; $display("FAIL r15_cx got=%0h/%0d exp=0/3", out, wr_addr); end
  endtask

  task automatic test_random();
    int op, ra;
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < 256; i++) begin
        op = $urandom_range(0, 15);
        if (op == 15 && $urandom_range(0, 7) != 0) op = 0;
        ra = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
        prog[i] = e_i(op, ra, $urandom_range(0, 255));
      end
      tick(1'b1, 1'b1);
      for (int t = 0; t < 300; t++) begin
        tick(($urandom_range(0, 9) != 0), ($urandom_range(0, 99) == 0));
        n_cmp++; if (imem_addr !== 8'(m_pc)) begin n_err++; $display("FAIL rnd_pc t=%0d got=%0d exp=%0d", t, imem_addr, m_pc); end
        n_cmp++; if (out !== 8'(m_out) || wr_addr !== 16'(m_wa)) begin n_err++; $display("FAIL rnd_out t=%0d got=%0h/%0h exp=%0h/%0h", t, out, wr_addr, m_out, m_wa); end
        n_cmp++; if (out_valid !== 1'(m_ov)) begin n_err++; $display("FAIL rnd_ov t=%0d got=%b exp=%0d", t, out_valid, m_ov); end
        n_cmp++; if (carry !== 1'(m_carry) || halted !== 1'(m_halt)) begin n_err++; $display("FAIL rnd_flags t=%0d got=%b/%b exp=%0d/%0d", t, carry, halted, m_carry, m_halt); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_wro();
    test_arith();
    test_carry();
    test_loop();
    test_stall();
    test_reset_cases();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
